// File: rtl/port_arbiter.sv
// Neighbor-port transfer arbiter: one read or write per request, targeted at a port, ANY or LAST.
// Define PORT_ARBITER_LAST_EN to enable LAST tracking; otherwise LAST behaves as NIL.
module port_arbiter #(
    parameter int WORD_W = 11
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  req,
    input  logic [2:0]            dir,
    input  logic                  wr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic                  cancel,
    input  logic [3:0]            nb_valid,
    input  logic [4*WORD_W-1:0]   nb_data,
    input  logic [3:0]            nb_ready,
    output logic [3:0]            nb_ack,
    output logic [3:0]            tx_valid,
    output logic [WORD_W-1:0]     tx_data,
    output logic                  done,
    output logic [WORD_W-1:0]     rdata,
    output logic [1:0]            last_dir
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] WR_WAIT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [3:0]        mask_q, mask_d;
    logic [3:0]        tx_valid_q, tx_valid_d;
    logic [WORD_W-1:0] tx_data_q, tx_data_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              last_valid_cur;
    logic [1:0]        last_dir_cur;
    logic [3:0]        req_mask;
    logic [3:0]        win;
    logic [1:0]        win_idx;
    logic              hit;

    // Fixed ANY priority: LEFT, RIGHT, UP, DOWN.
    function automatic logic [1:0] pick(input logic [3:0] w);
        if (w[2])      return 2'd2;
        else if (w[3]) return 2'd3;
        else if (w[0]) return 2'd0;
        else           return 2'd1;
    endfunction

`ifdef PORT_ARBITER_LAST_EN
    logic       any_q, any_d;
    logic       last_valid_q, last_valid_d;
    logic [1:0] last_dir_q, last_dir_d;

    assign last_valid_cur = last_valid_q;
    assign last_dir_cur   = last_dir_q;

    always_comb begin
        any_d        = any_q;
        last_valid_d = last_valid_q;
        last_dir_d   = last_dir_q;
        if (state_q == IDLE && req)
            any_d = (dir == 3'd4);
        if (hit && any_q) begin
            last_valid_d = 1'b1;
            last_dir_d   = win_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            any_q        <= 1'b0;
            last_valid_q <= 1'b0;
            last_dir_q   <= '0;
        end else begin
            any_q        <= any_d;
            last_valid_q <= last_valid_d;
            last_dir_q   <= last_dir_d;
        end
    end
`else
    assign last_valid_cur = 1'b0;
    assign last_dir_cur   = '0;
`endif

    always_comb begin
        req_mask = '0;
        case (dir)
            3'd0, 3'd1, 3'd2, 3'd3: req_mask = 4'b0001 << dir[1:0];
            3'd4:                   req_mask = 4'b1111;
            3'd5:                   req_mask = last_valid_cur ? (4'b0001 << last_dir_cur) : 4'b0000;
            default:                req_mask = '0;
        endcase
    end

    always_comb begin
        win = '0;
        if (state_q == RD_WAIT)
            win = mask_q & nb_valid;
        else if (state_q == WR_WAIT)
            win = tx_valid_q & nb_ready;
    end

    assign win_idx = pick(win);
    assign hit     = (|win) && !cancel;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    mask_d    = req_mask;
                    tx_data_d = wdata;
                    if (req_mask == 4'b0000) begin
                        state_d = DONE;
                        if (!wr)
                            rdata_d = '0;
                    end else if (wr) begin
                        state_d    = WR_WAIT;
                        tx_valid_d = req_mask;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (hit) begin
                    rdata_d = nb_data[int'(win_idx)*WORD_W +: WORD_W];
                    state_d = DONE;
                end
            end
            WR_WAIT: begin
                if (cancel) begin
                    state_d    = IDLE;
                    tx_valid_d = '0;
                end else if (hit) begin
                    state_d    = DONE;
                    tx_valid_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            tx_valid_q <= '0;
            tx_data_q  <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rdata_q    <= rdata_d;
        end
    end

    assign nb_ack   = (state_q == RD_WAIT && hit) ? (4'b0001 << win_idx) : 4'b0000;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign done     = (state_q == DONE);
    assign rdata    = rdata_q;
    assign last_dir = last_dir_cur;

endmodule

// File: tb/tb_port_arbiter.sv
// Bench for port_arbiter: directed vector table, hand-written corner sequences, random transactions.
module tb_port_arbiter;

    localparam int W = 11;
`ifdef PORT_ARBITER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           nRST, req, wr, cancel;
    logic [2:0]     dir;
    logic [W-1:0]   wdata;
    logic [3:0]     nb_valid, nb_ready, nb_ack, tx_valid;
    logic [4*W-1:0] nb_data;
    logic [W-1:0]   tx_data, rdata;
    logic           done;
    logic [1:0]     last_dir;

    port_arbiter #(.WORD_W(W)) dut (
        .CLK(CLK), .nRST(nRST), .req(req), .dir(dir), .wr(wr), .wdata(wdata),
        .cancel(cancel), .nb_valid(nb_valid), .nb_data(nb_data), .nb_ready(nb_ready),
        .nb_ack(nb_ack), .tx_valid(tx_valid), .tx_data(tx_data), .done(done),
        .rdata(rdata), .last_dir(last_dir)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] pdata [4];
    logic         m_lv;
    logic [1:0]   m_ld;
    logic [W-1:0] m_rdata;
    int           prio [4] = '{2, 3, 0, 1};

    typedef struct {
        logic [2:0]   dir;
        logic         wr;
        logic [W-1:0] wdata;
        logic         nil;
        logic [3:0]   offer;
        logic [3:0]   exp_ack;
        logic [3:0]   exp_tx;
        logic [W-1:0] exp_rdata;
        logic [1:0]   exp_last;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic load_data();
        for (int i = 0; i < 4; i++) nb_data[i*W +: W] = pdata[i];
    endtask

    task automatic idle_inputs();
        req = 1'b0; cancel = 1'b0; nb_valid = '0; nb_ready = '0;
    endtask

    function automatic logic [3:0] tmask(input logic [2:0] d);
        if (d < 3'd4)  return 4'b0001 << d[1:0];
        if (d == 3'd4) return 4'b1111;
        if (d == 3'd5 && LAST_EN && m_lv) return 4'b0001 << m_ld;
        return 4'b0000;
    endfunction

    function automatic logic [1:0] winner(input logic [3:0] w);
        for (int i = 0; i < 4; i++)
            if (w[prio[i]]) return 2'(prio[i]);
        return 2'd0;
    endfunction

    task automatic issue(input logic [2:0] d, input logic w, input logic [W-1:0] wd);
        req = 1'b1; dir = d; wr = w; wdata = wd;
        step();
        req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string tag;
        tag = $sformatf("vec%0d", n);
        issue(v.dir, v.wr, v.wdata);
        if (v.nil) begin
            chk({tag, "_nil_done"}, 32'(done), 32'd1);
            chk({tag, "_nil_ack"}, 32'(nb_ack), 32'd0);
            chk({tag, "_nil_tx"}, 32'(tx_valid), 32'd0);
            if (!v.wr) chk({tag, "_nil_rdata"}, 32'(rdata), 32'(v.exp_rdata));
            step();
            chk({tag, "_nil_done_end"}, 32'(done), 32'd0);
            return;
        end
        chk({tag, "_tx_wait"}, 32'(tx_valid), 32'(v.exp_tx));
        chk({tag, "_ack_wait"}, 32'(nb_ack), 32'd0);
        if (v.wr) nb_ready = v.offer; else nb_valid = v.offer;
        #1;
        chk({tag, "_ack"}, 32'(nb_ack), 32'(v.exp_ack));
        step();
        idle_inputs();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_tx_after"}, 32'(tx_valid), 32'd0);
        chk({tag, "_last"}, 32'(last_dir), 32'(v.exp_last));
        if (v.wr) chk({tag, "_tx_data"}, 32'(tx_data), 32'(v.wdata));
        else      chk({tag, "_rdata"}, 32'(rdata), 32'(v.exp_rdata));
        step();
        chk({tag, "_done_end"}, 32'(done), 32'd0);
    endtask

    task automatic rand_txn(input int n);
        logic [2:0]   d;
        logic         w, cx;
        logic [W-1:0] wd;
        logic [3:0]   t, off;
        logic [1:0]   p;
        string        tag;
        tag = $sformatf("rnd%0d", n);
        for (int i = 0; i < 4; i++) pdata[i] = W'($urandom);
        load_data();
        d  = 3'($urandom_range(0, 7));
        w  = 1'($urandom_range(0, 1));
        wd = W'($urandom);
        t  = tmask(d);
        cancel = 1'($urandom_range(0, 1));
        issue(d, w, wd);
        cancel = 1'b0;
        if (t == 4'b0000) begin
            if (!w) m_rdata = '0;
            chk({tag, "_nil_done"}, 32'(done), 32'd1);
            chk({tag, "_nil_rdata"}, 32'(rdata), 32'(m_rdata));
            chk({tag, "_nil_tx"}, 32'(tx_valid), 32'd0);
            step();
            chk({tag, "_nil_end"}, 32'(done), 32'd0);
            return;
        end
        chk({tag, "_tx_entry"}, 32'(tx_valid), 32'(w ? t : 4'b0000));
        repeat ($urandom_range(0, 2)) begin
            req = 1'($urandom_range(0, 1));
            dir = 3'($urandom_range(0, 7));
            if (w) begin nb_ready = 4'($urandom) & ~t; nb_valid = 4'($urandom); end
            else   begin nb_valid = 4'($urandom) & ~t; nb_ready = 4'($urandom); end
            #1;
            chk({tag, "_ack_idle"}, 32'(nb_ack), 32'd0);
            step();
            chk({tag, "_done_idle"}, 32'(done), 32'd0);
            chk({tag, "_tx_hold"}, 32'(tx_valid), 32'(w ? t : 4'b0000));
        end
        req = 1'b0;
        off = 4'($urandom) & t;
        if (off == 4'b0000) off = t;
        p  = winner(off);
        cx = ($urandom_range(0, 4) == 0);
        cancel = cx;
        if (w) begin nb_ready = off; nb_valid = 4'($urandom); end
        else   begin nb_valid = off; nb_ready = 4'($urandom); end
        #1;
        chk({tag, "_ack"}, 32'(nb_ack), 32'((w || cx) ? 4'b0000 : (4'b0001 << p)));
        step();
        idle_inputs();
        chk({tag, "_tx_after"}, 32'(tx_valid), 32'd0);
        if (cx) begin
            chk({tag, "_cancel_done"}, 32'(done), 32'd0);
            return;
        end
        if (!w) m_rdata = pdata[p];
        if (LAST_EN && d == 3'd4) begin m_lv = 1'b1; m_ld = p; end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_rdata"}, 32'(rdata), 32'(m_rdata));
        chk({tag, "_tx_data"}, 32'(tx_data), 32'(wd));
        chk({tag, "_last"}, 32'(last_dir), 32'(LAST_EN ? m_ld : 2'd0));
        step();
        chk({tag, "_done_end"}, 32'(done), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(nb_ack), 32'd0);
        chk({tag, "_tx"}, 32'(tx_valid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
        chk({tag, "_last"}, 32'(last_dir), 32'd0);
    endtask

    initial begin
        pdata[0] = W'(100); pdata[1] = W'(-200); pdata[2] = W'(37); pdata[3] = W'(999);
        load_data();
        dir = 3'd0; wr = 1'b0; wdata = '0;
        idle_inputs();

        // Reset dominates live inputs.
        nRST = 1'b1; req = 1'b1; dir = 3'd4; wr = 1'b1; wdata = W'(55); nb_ready = 4'hF; nb_valid = 4'hF;
        @(negedge CLK); step(); step();
        nRST = 1'b0; idle_inputs();
        chk_all_zero("reset");
        step(); step(); step();

        //             dir  wr  wdata      nil  offer    ack      tx       rdata      last
        vt[0] = '{3'd5, 1'b0, W'(0),  1'b1, 4'b0000, 4'b0000, 4'b0000, W'(0),  2'd0};
        vt[1] = '{3'd2, 1'b0, W'(0),  1'b0, 4'b0100, 4'b0100, 4'b0000, W'(37), 2'd0};
        vt[2] = '{3'd4, 1'b0, W'(0),  1'b0, 4'b1101, 4'b0100, 4'b0000, W'(37), LAST_EN ? 2'd2 : 2'd0};
        if (LAST_EN) vt[3] = '{3'd5, 1'b0, W'(0), 1'b0, 4'b1100, 4'b0100, 4'b0000, W'(37), 2'd2};
        else         vt[3] = '{3'd5, 1'b0, W'(0), 1'b1, 4'b0000, 4'b0000, 4'b0000, W'(0),  2'd0};
        vt[4] = '{3'd4, 1'b1, W'(-5), 1'b0, 4'b0011, 4'b0000, 4'b1111, W'(0),  2'd0};
        vt[5] = '{3'd1, 1'b0, W'(0),  1'b0, 4'b0010, 4'b0010, 4'b0000, W'(-200), 2'd0};
        vt[6] = '{3'd3, 1'b1, W'(999), 1'b0, 4'b1001, 4'b0000, 4'b1000, W'(0), 2'd0};
        vt[7] = '{3'd4, 1'b0, W'(0),  1'b0, 4'b1000, 4'b1000, 4'b0000, W'(999), LAST_EN ? 2'd3 : 2'd0};
        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Cancel wins over a same-cycle match, then the block is idle again.
        issue(3'd3, 1'b0, W'(0));
        nb_valid = 4'b1000; cancel = 1'b1;
        #1;
        chk("cancel_ack", 32'(nb_ack), 32'd0);
        step();
        idle_inputs();
        chk("cancel_done", 32'(done), 32'd0);
        nb_valid = 4'b1000;
        #1;
        chk("cancel_idle_ack", 32'(nb_ack), 32'd0);
        step();
        chk("cancel_idle_done", 32'(done), 32'd0);
        idle_inputs();

        // Reset during WR_WAIT; LAST afterwards must behave as NIL.
        issue(3'd1, 1'b1, W'(77));
        chk("rst_wr_tx", 32'(tx_valid), 32'b0010);
        nb_ready = 4'b0010; nRST = 1'b1;
        step();
        nRST = 1'b0; idle_inputs();
        chk_all_zero("rst_mid");
        step();
        chk("rst_mid_nodone", 32'(done), 32'd0);
        issue(3'd5, 1'b0, W'(0));
        chk("rst_last_nil_done", 32'(done), 32'd1);
        chk("rst_last_nil_rdata", 32'(rdata), 32'd0);
        step();

        m_lv = 1'b0; m_ld = 2'd0; m_rdata = '0;
        for (int i = 0; i < 300; i++) rand_txn(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 WORD_W, 11, data word width (TIS value range -999..999, two's complement).
REQ-002 CLK  in  1  single clock; all state on rising edge.
REQ-003 nRST  in  1  reset, synchronous and active-high (name follows codebase convention; polarity and synchronicity fixed).
REQ-004 req  in  1  start a transfer; sampled in IDLE only.
REQ-005 dir  in  3  target: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 ANY, 5 LAST, 6 NIL, 7 reserved (treated as NIL).
REQ-006 wr  in  1  1 = write to neighbor, 0 = read from neighbor.
REQ-007 wdata  in  WORD_W  write data, latched with req.
REQ-008 cancel  in  1  abort the pending transfer.
REQ-009 nb_valid  in  4  neighbor offers data, bit index 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
REQ-010 nb_data  in  4*WORD_W  neighbor data, slice i = port i.
REQ-011 nb_ready  in  4  neighbor is reading from this node.
REQ-012 nb_ack  out  4  consume nb_data on port i this cycle.
REQ-013 tx_valid  out  4  this node offers tx_data on port i.
REQ-014 tx_data  out  WORD_W  latched write data, shared by all ports.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 rdata  out  WORD_W  read result; valid while done=1, held until next completion.
REQ-017 last_dir  out  2  port index of the most recent ANY transfer.

Function
REQ-018 FSM states IDLE, RD_WAIT, WR_WAIT, DONE; encoding free.
REQ-019 IDLE & req: latch dir, wr, wdata; next state RD_WAIT (wr=0) or WR_WAIT (wr=1); req in any other state is ignored.
REQ-020 Target mask: single port for 0-3; all four for ANY; recorded last port for LAST.
REQ-021 NIL, reserved, or LAST with no recorded port: IDLE -> DONE directly, no port activity, rdata=0 for reads, write discarded.
REQ-022 RD_WAIT: win = target mask & nb_valid; when nonzero and cancel=0, assert nb_ack on exactly one winner combinationally in that cycle, capture its nb_data into rdata, and go to DONE.
REQ-023 WR_WAIT: tx_valid = target mask (registered, from the cycle after entry); win = tx_valid & nb_ready; when nonzero and cancel=0, the transfer completes on one winner, and tx_valid goes to 0 on all ports the next cycle; go to DONE.
REQ-024 ANY priority when several ports win in one cycle: LEFT, RIGHT, UP, DOWN (fixed).
REQ-025 Any transfer whose dir was ANY records the winning port in last_dir and sets the internal last_valid flag; other transfers leave both unchanged.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; minimum latency req -> done is 2 cycles for port transfers and 1 cycle for NIL.
REQ-027 cancel in RD_WAIT/WR_WAIT: return to IDLE next cycle, no done, no nb_ack, tx_valid cleared; cancel overrides a same-cycle match.
REQ-028 cancel in IDLE or DONE has no effect.
REQ-029 No timeout: wait states hold indefinitely until match or cancel.
REQ-030 nb_ack is never asserted outside RD_WAIT; tx_valid is never asserted outside WR_WAIT.

Reset
REQ-031 nRST=1 at a rising edge: state IDLE; nb_ack, tx_valid, done = 0; tx_data, rdata = 0; last_dir = 0; last_valid = 0.
REQ-032 Reset mid-transfer aborts the transfer with no done and no acknowledge; reset takes priority over all other inputs.

Configuration
REQ-033 Macro PORT_ARBITER_LAST_EN defined: LAST tracking per REQ-020/025 is implemented.
REQ-034 Macro undefined: no last register; LAST behaves as NIL (REQ-021); last_dir is tied to 0.

Verification
REQ-035 Read LEFT, nb_valid=0100 after 3 idle cycles, nb_data[LEFT]=37 -> nb_ack=0100 for one cycle, done one cycle later with rdata=37.
REQ-036 Read ANY, nb_valid=1101 simultaneously -> nb_ack=0100 (LEFT wins), last_dir=2; a following read LAST with nb_valid=1100 -> nb_ack=0100.
REQ-037 Write ANY wdata=-5 -> tx_valid=1111; nb_ready=0011 -> UP wins, last_dir=0, tx_valid=0000 next cycle, done pulse, tx_data=-5.
REQ-038 Read RIGHT, then cancel=1 in the same cycle as nb_valid=1000 -> no nb_ack, no done, IDLE next cycle.
REQ-039 Read LAST after reset -> done 1 cycle after req, rdata=0, no nb_ack; with macro undefined, the same result after a prior ANY transfer.
REQ-040 nRST=1 while in WR_WAIT with tx_valid=0010 -> next cycle all outputs 0, state IDLE, last_valid=0.
